// File: rtl/mac_rr_sched.sv
// mac_rr_sched: round-robin scheduler sharing one 8x8 multiply-accumulate unit across NREQ requesters.
// Define MAC_RR_SCHED_SAT_EN to make the 16-bit accumulator saturate instead of wrapping.
module mac_rr_sched #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 8,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*LEN_W-1:0] req_len,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       op_valid,
   input  logic [NREQ*8-1:0]     op_a,
   input  logic [NREQ*8-1:0]     op_b,
   output logic [NREQ-1:0]       op_ready,
   output logic                  res_valid,
   output logic [15:0]           res_data,
   output logic [ID_W-1:0]       res_id,
   input  logic                  res_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       acc_q, acc_d;
   logic [15:0]       res_data_q, res_data_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;

   logic [7:0]        a_arr   [NREQ];
   logic [7:0]        b_arr   [NREQ];
   logic [LEN_W-1:0]  len_arr [NREQ];
   logic [ID_W-1:0]   rot_idx [NREQ];
   logic [NREQ-1:0]   rot_req;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [15:0]       prod;
   logic [15:0]       acc_sum;

   // rot_req[gi] is the request sitting gi places after the priority pointer
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         logic [ID_W:0] sum;
         assign a_arr[gi]   = op_a[gi*8 +: 8];
         assign b_arr[gi]   = op_b[gi*8 +: 8];
         assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
         assign sum         = {1'b0, ptr_q} + (ID_W+1)'(gi);
         assign rot_idx[gi] = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ))
                                                       : sum[ID_W-1:0];
         assign rot_req[gi] = req_valid[rot_idx[gi]];
      end
   endgenerate

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         if (rot_req[k]) begin
            win_found = 1'b1;
            win_idx   = rot_idx[k];
         end
      end
   end

   assign prod = {8'd0, a_arr[id_q]} * {8'd0, b_arr[id_q]};

`ifdef MAC_RR_SCHED_SAT_EN
   logic [16:0] sum_wide;
   assign sum_wide = {1'b0, acc_q} + {1'b0, prod};
   assign acc_sum  = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
`else
   assign acc_sum  = acc_q + prod;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      req_ready  = '0;
      op_ready   = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               // Mealy grant; masked so every output reads 0 while reset is held
               req_ready[win_idx] = ~reset;
               id_d  = win_idx;
               cnt_d = len_arr[win_idx];
               acc_d = '0;
               ptr_d = (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
               if (len_arr[win_idx] == '0) begin
                  state_d    = S_DONE;
                  res_data_d = '0;
                  res_id_d   = win_idx;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            op_ready[id_q] = 1'b1;
            if (op_valid[id_q]) begin
               acc_d = acc_sum;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d    = S_DONE;
                  res_data_d = acc_sum;
                  res_id_d   = id_q;
               end
            end
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
      end
   end

   assign res_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_mac_rr_sched.sv
// Scoreboard bench for mac_rr_sched: stimulus pushes expected results, a monitor pops them on each
// accepted result; extra directed checks cover grants, reset, zero-length jobs and stalls.
module tb_mac_rr_sched;

   localparam int NREQ  = 4;
   localparam int LEN_W = 8;
   localparam int ID_W  = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*LEN_W-1:0] req_len;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       op_valid;
   logic [NREQ*8-1:0]     op_a;
   logic [NREQ*8-1:0]     op_b;
   logic [NREQ-1:0]       op_ready;
   logic                  res_valid;
   logic [15:0]           res_data;
   logic [ID_W-1:0]       res_id;
   logic                  res_ready;
   logic                  busy;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [15:0]     data;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] va [8];
   logic [7:0] vb [8];

   mac_rr_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
      .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] data);
      exp_t e;
      e.id   = ID_W'(id);
      e.data = data;
      exp_q.push_back(e);
   endtask

   // waits for the next grant, checks it went to idx, returns just after the accept edge
   task automatic grant_expect(input int idx, input string name);
      bit seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            seen = 1'b1;
            check(name, 32'(req_ready), 32'(1) << idx);
         end
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL %s: no grant within 60 cycles, expected req_ready=%0h", name, 1 << idx);
      end
      @(posedge clk);
      #1;
   endtask

   // feeds n operand pairs from va/vb to requester i; toggle gives op_valid 1-0-1-0
   task automatic send_ops(input int i, input int n, input bit toggle);
      int k   = 0;
      int cyc = 0;
      while (k < n && cyc < 100) begin
         op_valid[i]    = toggle ? (cyc % 2 == 0) : 1'b1;
         op_a[i*8 +: 8] = va[k];
         op_b[i*8 +: 8] = vb[k];
         @(negedge clk);
         if (op_valid[i] && op_ready[i]) k++;
         @(posedge clk);
         #1;
         cyc++;
      end
      op_valid[i] = 1'b0;
      if (k < n) begin
         errors++;
         checks++;
         $display("FAIL beats req%0d: got %0d beats, expected %0d", i, k, n);
      end
   endtask

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected result: got id=%0d data=%0h, expected none", res_id, res_data);
            end else begin
               e = exp_q.pop_front();
               check("res_id", 32'(res_id), 32'(e.id));
               check("res_data", 32'(res_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_len   = '0;
      op_valid  = '0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 0);
      check("reset res_valid", 32'(res_valid), 0);
      check("reset res_data", 32'(res_data), 0);
      reset = 1'b0;

      // single job on req0: 2*3 + 4*5 + 10*10 = 126
      push_exp(0, 16'h007E);
      req_len[0*LEN_W +: LEN_W] = 8'd3;
      req_valid[0] = 1'b1;
      grant_expect(0, "grant single req0");
      req_valid[0] = 1'b0;
      va[0] = 8'd2;  vb[0] = 8'd3;
      va[1] = 8'd4;  vb[1] = 8'd5;
      va[2] = 8'd10; vb[2] = 8'd10;
      send_ops(0, 3, 1'b0);
      @(negedge clk);
      check("res_valid after last beat", 32'(res_valid), 1);
      @(posedge clk);
      #1;

      // overflow on req3: 2 * 65025 mod 2^16 = FC02
`ifdef MAC_RR_SCHED_SAT_EN
      push_exp(3, 16'hFFFF);
`else
      push_exp(3, 16'hFC02);
`endif
      req_len[3*LEN_W +: LEN_W] = 8'd2;
      req_valid[3] = 1'b1;
      grant_expect(3, "grant overflow req3");
      req_valid[3] = 1'b0;
      va[0] = 8'd255; vb[0] = 8'd255;
      va[1] = 8'd255; vb[1] = 8'd255;
      send_ops(3, 2, 1'b0);

      // fairness: all four len 1, operands (i+1)*3
      for (int i = 0; i < NREQ; i++) begin
         req_len[i*LEN_W +: LEN_W] = 8'd1;
         op_a[i*8 +: 8] = 8'(i + 1);
         op_b[i*8 +: 8] = 8'd3;
      end
      op_valid  = '1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) begin
         push_exp(i, 16'((i + 1) * 3));
         grant_expect(i, $sformatf("fair grant %0d", i));
         req_valid[i] = 1'b0;
      end
      // req0 and req2 held high: they must alternate
      req_valid[0] = 1'b1;
      req_valid[2] = 1'b1;
      for (int r = 0; r < 4; r++) begin
         push_exp((r % 2) * 2, 16'(((r % 2) * 2 + 1) * 3));
         grant_expect((r % 2) * 2, $sformatf("alt grant %0d", r));
      end
      req_valid = '0;

      // zero-length job on req1
      push_exp(1, 16'h0000);
      req_len[1*LEN_W +: LEN_W] = 8'd0;
      req_valid[1] = 1'b1;
      grant_expect(1, "grant zero-len req1");
      req_valid[1] = 1'b0;
      op_valid = '0;
      @(negedge clk);
      check("zero-len res_valid T+1", 32'(res_valid), 1);
      check("zero-len op_ready", 32'(op_ready), 0);
      @(posedge clk);
      #1;

      // stalls on req2, len 4: 2 + 12 + 30 + 56 = 100; req3 waits meanwhile
      push_exp(2, 16'd100);
      req_len[2*LEN_W +: LEN_W] = 8'd4;
      req_valid[2] = 1'b1;
      grant_expect(2, "grant stall req2");
      req_valid[2] = 1'b0;
      req_len[3*LEN_W +: LEN_W] = 8'd0;
      req_valid[3] = 1'b1;
      res_ready = 1'b0;
      va[0] = 8'd1; vb[0] = 8'd2;
      va[1] = 8'd3; vb[1] = 8'd4;
      va[2] = 8'd5; vb[2] = 8'd6;
      va[3] = 8'd7; vb[3] = 8'd8;
      send_ops(2, 4, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold res_valid", 32'(res_valid), 1);
         check("hold res_data", 32'(res_data), 100);
         check("hold busy", 32'(busy), 1);
         check("hold no grant", 32'(req_ready), 0);
         @(posedge clk);
         #1;
      end
      push_exp(3, 16'h0000);
      res_ready = 1'b1;
      grant_expect(3, "grant req3 after stall");
      req_valid[3] = 1'b0;

      // reset after 2 of 4 beats on req2; req1 and req3 pending
      req_len[2*LEN_W +: LEN_W] = 8'd4;
      req_valid[2] = 1'b1;
      grant_expect(2, "grant mid-reset req2");
      req_valid[2] = 1'b0;
      va[0] = 8'd9; vb[0] = 8'd9;
      va[1] = 8'd9; vb[1] = 8'd9;
      send_ops(2, 2, 1'b0);
      req_len[1*LEN_W +: LEN_W] = 8'd2;
      req_len[3*LEN_W +: LEN_W] = 8'd1;
      req_valid[1] = 1'b1;
      req_valid[3] = 1'b1;
      op_valid[2]  = 1'b1;
      reset = 1'b1;
      #1;
      check("async reset busy", 32'(busy), 0);
      check("async reset req_ready", 32'(req_ready), 0);
      check("async reset op_ready", 32'(op_ready), 0);
      check("async reset res_valid", 32'(res_valid), 0);
      check("async reset res_id", 32'(res_id), 0);
      op_valid[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      // ptr back at 0, so req1 beats req3; acc restarts: 3*4 + 5*6 = 42
      push_exp(1, 16'd42);
      grant_expect(1, "grant after reset req1");
      req_valid[1] = 1'b0;
      va[0] = 8'd3; vb[0] = 8'd4;
      va[1] = 8'd5; vb[1] = 8'd6;
      send_ops(1, 2, 1'b0);
      push_exp(3, 16'd49);
      grant_expect(3, "grant after reset req3");
      req_valid[3] = 1'b0;
      va[0] = 8'd7; vb[0] = 8'd7;
      send_ops(3, 1, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mac_rr_sched.md
# mac_rr_sched

Round-robin scheduler that shares one 8x8 multiply-accumulate datapath between `NREQ` requesters, each submitting a dot-product job. The block:
- grants one job at a time;
- streams that requester's operand pairs into an internal 16-bit accumulator, cleared per job;
- returns the result tagged with the requester ID over a valid/ready handshake.

It sits between the requesting engines and the shared MAC resource.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `LEN_W`, default 8: width of each job length field.
- `ID_W`, default 2: requester ID width; must equal `max(1, clog2(NREQ))`.

Ports (clock and reset first):
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester job request. Must be held until the matching `req_ready`.
- `req_len`  in  NREQ*LEN_W  job length in operand pairs; requester i uses bits `[i*LEN_W +: LEN_W]`.
- `req_ready`  out  NREQ  one-hot, one-cycle job-accept pulse.
- `op_valid`  in  NREQ  per-requester operand-pair valid.
- `op_a`, `op_b`  in  NREQ*8 each  unsigned operands; requester i uses `[i*8 +: 8]`.
- `op_ready`  out  NREQ  one-hot; only the granted requester, only in RUN.
- `res_valid`  out  1  result available.
- `res_data`  out  16  accumulated result.
- `res_id`  out  ID_W  requester that owns `res_data`.
- `res_ready`  in  1  result consumer accept.
- `busy`  out  1  high in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. All outputs reset to 0: `req_ready`, `op_ready`, `res_valid`, `res_data`, `res_id`, `busy`. On reset, the state goes to IDLE and the priority pointer `ptr` goes to 0.
- **IDLE (arbitration):**
  - Search `req_valid` starting at index `ptr`, ascending, wrapping modulo NREQ. The first set bit wins.
  - `req_ready[win]` is driven combinationally (Mealy) in that same cycle.
  - On that edge, latch `id = win` and `cnt = req_len[win]`, clear `acc` to 0, and set `ptr = (win+1) mod NREQ`.
  - Next state is RUN if `len != 0`, otherwise DONE.
- **RUN:**
  - `op_ready[id] = 1`; all other `op_ready` bits are 0.
  - A beat occurs when `op_valid[id]` and `op_ready[id]` are both high. On each beat: `acc <= acc + op_a[id]*op_b[id]`, with the 16-bit product zero-extended and the sum taken mod 2^16, and `cnt` decrements by 1.
  - The beat with `cnt == 1` is the last one; next state is DONE.
  - `op_valid` may drop at any time; this is a stall with no accumulation.
- **DONE:**
  - `res_valid = 1`, with `res_data = acc` and `res_id = id` held stable.
  - When `res_ready` is high, go to IDLE.
  - No new grants are issued while in RUN or DONE.
- **Ignored inputs:** `req_valid` and `op_valid` from non-granted requesters are ignored and never consumed.
- **Arithmetic:** operands are unsigned, the product is 16 bits, and the accumulator is 16 bits. The accumulator wraps unless the saturation macro is defined (see Configuration).

## Timing
- Job accepted in cycle T (the `req_ready` pulse); the first operand can be consumed in T+1.
- `res_valid` rises on the cycle after the last beat is accepted.
- A `len = 0` job has `res_valid` high in T+1 with `res_data = 0`, and no `op_ready` is ever asserted.
- Minimum job occupancy is 1 (accept) + len (beats) + 1 (result) cycles. At least one IDLE cycle separates the `res_ready` handshake from the next `req_ready`.
- `res_data` and `res_id` are registered and change only on entry to DONE.
- **Reset mid-job:** the job is aborted on the asynchronous assertion. No result is produced. On release the FSM is in IDLE with `ptr = 0`, and pending requests are re-arbitrated from index 0.

## Configuration
- Macro: `MAC_RR_SCHED_SAT_EN`.
- **Defined:** each accumulate saturates at 16'hFFFF. Once `acc` reaches 16'hFFFF it stays there until the next job clears it.
- **Undefined:** each accumulate wraps modulo 2^16.

## Test plan
- **Single job, no backpressure:** req0 with len 3 and pairs (2,3), (4,5), (10,10) gives `res_data = 16'h007E` and `res_id = 0`, with `res_valid` one cycle after the third beat.
- **Overflow:** len 2 with pairs (255,255), (255,255) gives 16'hFC02 without the macro and 16'hFFFF with `MAC_RR_SCHED_SAT_EN` defined.
- **Fairness:**
  - Assert all 4 `req_valid` with len 1. Grants must occur in order 0, 1, 2, 3, each with the correct `res_id`.
  - Then hold req0 and req2 high. Grants must follow as 0 then 2, and req2 must not be starved.
- **Zero length:** req1 with len 0 gives `res_valid` in the cycle after `req_ready`, with `res_data = 0`, `res_id = 1`, and `op_ready` held at 0 throughout.
- **Stalls:** len 4 with `op_valid` toggling 1-0-1-0, then `res_ready` held low for 5 cycles.
  - Exactly 4 beats are accumulated.
  - `res_data` is stable while `res_valid` is held.
  - `busy` stays high and no other requester is granted meanwhile.
- **Reset mid-RUN:** assert `reset` after 2 of 4 beats.
  - All outputs read 0 immediately and no `res_valid` appears.
  - After release, requests re-arbitrate from index 0 and accumulation restarts from 0.
